// File: rtl/m68k_bus_responder.sv
// Target-side 68000 bus agent: decodes an address window, forwards hits to a
// local req/ack port and terminates the bus cycle with DTACK_n or BERR_n.
module m68k_bus_responder #(
  parameter logic [23:0] ADDR_BASE   = 24'hE80000,
  parameter logic [23:0] ADDR_MASK   = 24'hFF0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        PI_CLK,
  input  logic        RST,
  input  logic [23:1] M68K_A,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        LOC_REQ,
  output logic        LOC_WE,
  output logic [23:1] LOC_ADDR,
  output logic [1:0]  LOC_BE,
  output logic [15:0] LOC_WDATA,
  input  logic [15:0] LOC_RDATA,
  input  logic        LOC_ACK,
  input  logic        LOC_ERR
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_LOCAL, S_WAIT, S_ACK, S_IGNORE
  } state_t;

  state_t      state_q;
  logic [1:0]  as_sync_q, uds_sync_q, lds_sync_q;
  logic [23:1] addr_q;
  logic [2:0]  fc_q;
  logic        rw_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        we_q;
  logic        req_q;
  logic [15:0] dout_q;
  logic        oe_q;
  logic        dtack_n_q;
  logic        berr_n_q;
  logic [7:0]  tmo_q;
  logic [3:0]  ws_q;
  logic        err_q;
  logic        abort_q;

  logic as_s, uds_s, lds_s;
  logic hit, tmo_hit, loc_done, loc_fail;

  assign as_s  = as_sync_q[1];
  assign uds_s = uds_sync_q[1];
  assign lds_s = lds_sync_q[1];

  // Bit 0 of the window base is a byte lane, not part of the decode.
  assign hit = ((({addr_q, 1'b0} & ADDR_MASK) == ({ADDR_BASE[23:1], 1'b0} & ADDR_MASK))
               && (fc_q != 3'b111));

  assign tmo_hit  = (tmo_q == TO_LAST);
  assign loc_done = LOC_ACK | LOC_ERR | tmo_hit;
  // Error wins over ack; a bare timeout is also an error.
  assign loc_fail = LOC_ERR | ~LOC_ACK;

  always_ff @(posedge PI_CLK or posedge RST) begin
    if (RST) begin
      as_sync_q  <= 2'b11;
      uds_sync_q <= 2'b11;
      lds_sync_q <= 2'b11;
    end else begin
      as_sync_q  <= {as_sync_q[0],  M68K_AS_n};
      uds_sync_q <= {uds_sync_q[0], M68K_UDS_n};
      lds_sync_q <= {lds_sync_q[0], M68K_LDS_n};
    end
  end

  always_ff @(posedge PI_CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      fc_q      <= '0;
      rw_q      <= 1'b1;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      tmo_q     <= '0;
      ws_q      <= '0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Writes only qualify once a data strobe is low, so D_IN is valid.
          if (!as_s && (!uds_s || !lds_s)) begin
            addr_q  <= M68K_A;
            fc_q    <= M68K_FC;
            rw_q    <= M68K_RW;
            wdata_q <= M68K_D_IN;
            be_q    <= {~uds_s, ~lds_s};
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (hit) begin
            req_q   <= 1'b1;
            we_q    <= ~rw_q;
            tmo_q   <= '0;
            abort_q <= as_s;
            state_q <= S_LOCAL;
          end else begin
            state_q <= S_IGNORE;
          end
        end
        S_LOCAL: begin
          if (loc_done) begin
            req_q <= 1'b0;
            err_q <= loc_fail;
            if (rw_q && LOC_ACK && !LOC_ERR) dout_q <= LOC_RDATA;
            if (abort_q || as_s) begin
              state_q <= S_IDLE;
            end else if (WAIT_STATES == 0) begin
              if (loc_fail) begin
                berr_n_q <= 1'b0;
              end else begin
                dtack_n_q <= 1'b0;
                oe_q      <= rw_q;
              end
              state_q <= S_ACK;
            end else begin
              ws_q    <= '0;
              state_q <= S_WAIT;
            end
          end else begin
            tmo_q   <= tmo_q + 8'd1;
            abort_q <= abort_q | as_s;
          end
        end
        S_WAIT: begin
          if (as_s) begin
            state_q <= S_IDLE;
          end else if (ws_q == WS_LAST) begin
            if (err_q) begin
              berr_n_q <= 1'b0;
            end else begin
              dtack_n_q <= 1'b0;
              oe_q      <= rw_q;
            end
            state_q <= S_ACK;
          end else begin
            ws_q <= ws_q + 4'd1;
          end
        end
        S_ACK: begin
          if (as_s) begin
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            oe_q      <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_IGNORE: begin
          if (as_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign M68K_D_OUT   = dout_q;
  assign M68K_D_OE    = oe_q;
  assign M68K_DTACK_n = dtack_n_q;
  assign M68K_BERR_n  = berr_n_q;
  assign LOC_REQ      = req_q;
  assign LOC_WE       = we_q;
  assign LOC_ADDR     = addr_q;
  assign LOC_BE       = be_q;
  assign LOC_WDATA    = wdata_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: one zero-wait-state instance and one
// four-wait-state instance share the bus; local requests are scoreboarded.
module tb_m68k_bus_responder;

  logic        clk, rst;
  logic [23:1] a;
  logic [2:0]  fc;
  logic        as_n, uds_n, lds_n, rw;
  logic [15:0] din, rdata;
  logic        ack, err;

  logic [15:0] d0_dout, d4_dout;
  logic        d0_oe, d0_dtack, d0_berr, d0_req, d0_we;
  logic        d4_oe, d4_dtack, d4_berr, d4_req, d4_we;
  logic [23:1] d0_addr, d4_addr;
  logic [1:0]  d0_be, d4_be;
  logic [15:0] d0_wdata, d4_wdata;

  typedef struct packed {
    logic [23:1] addr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   fails  = 0;
  int   n;

  m68k_bus_responder #(.WAIT_STATES(0), .TIMEOUT(16)) dut0 (
    .PI_CLK(clk), .RST(rst), .M68K_A(a), .M68K_FC(fc), .M68K_AS_n(as_n),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_D_IN(din),
    .M68K_D_OUT(d0_dout), .M68K_D_OE(d0_oe), .M68K_DTACK_n(d0_dtack),
    .M68K_BERR_n(d0_berr), .LOC_REQ(d0_req), .LOC_WE(d0_we), .LOC_ADDR(d0_addr),
    .LOC_BE(d0_be), .LOC_WDATA(d0_wdata), .LOC_RDATA(rdata), .LOC_ACK(ack),
    .LOC_ERR(err));

  m68k_bus_responder #(.WAIT_STATES(4), .TIMEOUT(16)) dut4 (
    .PI_CLK(clk), .RST(rst), .M68K_A(a), .M68K_FC(fc), .M68K_AS_n(as_n),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_D_IN(din),
    .M68K_D_OUT(d4_dout), .M68K_D_OE(d4_oe), .M68K_DTACK_n(d4_dtack),
    .M68K_BERR_n(d4_berr), .LOC_REQ(d4_req), .LOC_WE(d4_we), .LOC_ADDR(d4_addr),
    .LOC_BE(d4_be), .LOC_WDATA(d4_wdata), .LOC_RDATA(rdata), .LOC_ACK(ack),
    .LOC_ERR(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("dtack_berr_exclusive", {d0_dtack | d0_berr, d4_dtack | d4_berr}, 2'b11);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic bus_start(input logic [23:0] addr, input logic [2:0] f,
                           input logic r, input logic u, input logic l,
                           input logic [15:0] d);
    a     = addr[23:1];
    fc    = f;
    rw    = r;
    din   = d;
    as_n  = 1'b0;
    uds_n = u;
    lds_n = l;
  endtask

  task automatic bus_end();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
  endtask

  // Waits for LOC_REQ, then pops and checks the expected local request.
  task automatic wait_req(output exp_t e);
    for (int i = 0; i < 20 && !d0_req; i++) tick();
    chk("req_seen", d0_req, 1'b1);
    chk("req_queue_nonempty", exp_q.size(), 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = '0;
    chk("loc_addr", d0_addr, e.addr);
    chk("loc_we", d0_we, e.we);
    chk("loc_be", d0_be, e.be);
    chk("loc_wdata", d0_wdata, e.wdata);
    chk("loc_d4_match", {d4_req, d4_addr, d4_we, d4_be, d4_wdata},
        {1'b1, e.addr, e.we, e.be, e.wdata});
  endtask

  // AS negation is seen after two syncs; bus releases on the following edge.
  task automatic finish_cycle(input string tag);
    bus_end();
    ticks(2);
    chk({tag, "_hold"}, {d0_dtack, d0_berr}, 2'b11 ^ {~d0_dtack, ~d0_berr});
    tick();
    chk({tag, "_release"}, {d0_dtack, d0_berr, d0_oe}, 3'b110);
    ticks(3);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; err = 1'b0; rdata = '0;
    a = '0; fc = 3'd5; rw = 1'b1; din = '0;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    #12;
    chk("rst_outputs", {d0_dtack, d0_berr, d0_oe, d0_req, d0_we},  5'b11000);
    chk("rst_dout", d0_dout, 16'h0);
    chk("rst_addr", d0_addr, 23'h0);
    chk("rst_be_wdata", {d0_be, d0_wdata}, 18'h0);
    chk("rst_d4", {d4_dtack, d4_berr, d4_oe, d4_req}, 4'b1100);
    rst = 1'b0;
    ticks(3);

    // Read hit, ack three cycles after LOC_REQ.
    exp_q.push_back('{addr: 23'h740008, we: 1'b0, be: 2'b11, wdata: 16'h0, rdata: 16'hBEEF});
    bus_start(24'hE80010, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cur);
    ticks(3);
    chk("read_pre_ack", {d0_req, d0_dtack, d0_oe}, 3'b110);
    ack = 1'b1; rdata = cur.rdata;
    tick();
    ack = 1'b0; rdata = 16'h0;
    chk("read_req_drop", d0_req, 1'b0);
    chk("read_dtack", {d0_dtack, d0_berr, d0_oe}, 3'b011);
    chk("read_dout", d0_dout, cur.rdata);
    chk("read_d4_waiting", d4_dtack, 1'b1);
    ticks(2);
    chk("read_dout_stable", {d0_oe, d0_dout}, {1'b1, cur.rdata});
    finish_cycle("read");

    // Byte write on the lower lane.
    exp_q.push_back('{addr: 23'h740010, we: 1'b1, be: 2'b01, wdata: 16'h00A5, rdata: 16'h0});
    bus_start(24'hE80021, 3'd5, 1'b0, 1'b1, 1'b0, 16'h00A5);
    wait_req(cur);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("write_dtack", {d0_req, d0_dtack, d0_berr, d0_oe}, 4'b0010);
    finish_cycle("write");

    // Misses: outside window, and IACK space inside the window.
    bus_start(24'hC00000, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("miss_quiet", {d0_req, d0_dtack, d0_berr, d4_req}, 4'b0110);
    end
    bus_end(); ticks(4);
    bus_start(24'hE80000, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("iack_quiet", {d0_req, d0_dtack, d0_berr, d4_req}, 4'b0110);
    end
    bus_end(); ticks(4);

    // Timeout: no ack for 16 cycles.
    exp_q.push_back('{addr: 23'h740100, we: 1'b0, be: 2'b10, wdata: 16'h0, rdata: 16'h0});
    bus_start(24'hE80200, 3'd5, 1'b1, 1'b0, 1'b1, 16'h0);
    wait_req(cur);
    n = 1;
    for (int i = 0; i < 40 && d0_req; i++) begin
      tick();
      if (d0_req) n++;
    end
    chk("timeout_req_cycles", n, 16);
    chk("timeout_berr", {d0_dtack, d0_berr, d0_oe}, 3'b100);
    ticks(2);
    chk("timeout_berr_hold", {d0_dtack, d0_berr}, 2'b10);
    finish_cycle("timeout");

    // Simultaneous ack and err: error wins.
    exp_q.push_back('{addr: 23'h740002, we: 1'b0, be: 2'b11, wdata: 16'h0, rdata: 16'h1111});
    bus_start(24'hE80004, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cur);
    ack = 1'b1; err = 1'b1; rdata = cur.rdata;
    tick();
    ack = 1'b0; err = 1'b0;
    chk("ackerr_berr_only", {d0_req, d0_dtack, d0_berr, d0_oe}, 4'b0100);
    finish_cycle("ackerr");

    // Four wait states: DTACK_n exactly five cycles after the ack cycle.
    exp_q.push_back('{addr: 23'h740040, we: 1'b1, be: 2'b11, wdata: 16'h3C3C, rdata: 16'h0});
    bus_start(24'hE80080, 3'd1, 1'b0, 1'b0, 1'b0, 16'h3C3C);
    wait_req(cur);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      chk($sformatf("ws4_dtack_c%0d", i), d4_dtack, (i == 5) ? 1'b0 : 1'b1);
    end
    chk("ws4_no_oe_on_write", d4_oe, 1'b0);
    bus_end(); ticks(3);
    chk("ws4_release", {d4_dtack, d4_berr}, 2'b11);
    ticks(2);

    // Master aborts while dut4 is still counting wait states.
    exp_q.push_back('{addr: 23'h740020, we: 1'b1, be: 2'b10, wdata: 16'h5500, rdata: 16'h0});
    bus_start(24'hE80040, 3'd1, 1'b0, 1'b0, 1'b1, 16'h5500);
    wait_req(cur);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    bus_end();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_quiet", {d4_dtack, d4_berr, d4_oe}, 3'b110);
    end
    exp_q.push_back('{addr: 23'h740006, we: 1'b0, be: 2'b11, wdata: 16'h0, rdata: 16'hC0DE});
    bus_start(24'hE8000C, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cur);
    ack = 1'b1; rdata = cur.rdata;
    tick();
    ack = 1'b0; rdata = 16'h0;
    ticks(4);
    chk("post_abort_d4", {d4_dtack, d4_oe, d4_dout}, {1'b0, 1'b1, cur.rdata});
    bus_end(); ticks(5);

    // Reset mid-cycle releases the bus without a clock edge.
    exp_q.push_back('{addr: 23'h740030, we: 1'b0, be: 2'b11, wdata: 16'h0, rdata: 16'h7777});
    bus_start(24'hE80060, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cur);
    ack = 1'b1; rdata = cur.rdata;
    tick();
    ack = 1'b0;
    chk("pre_reset_drive", {d0_dtack, d0_oe}, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_release", {d0_dtack, d0_berr, d0_oe, d0_dout}, {3'b110, 16'h0});
    bus_end();
    ticks(2);
    rst = 1'b0;
    ticks(3);
    exp_q.push_back('{addr: 23'h740001, we: 1'b0, be: 2'b11, wdata: 16'h0, rdata: 16'h5A5A});
    bus_start(24'hE80002, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cur);
    ack = 1'b1; rdata = cur.rdata;
    tick();
    ack = 1'b0; rdata = 16'h0;
    chk("post_reset_read", {d0_dtack, d0_oe, d0_dout}, {1'b0, 1'b1, cur.rdata});
    finish_cycle("post_reset");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Target-side 68000 bus agent. It watches a 68000 bus cycle driven by another master (AS_n/UDS_n/LDS_n/RW/FC/A) in an address window.
- It forwards each hit to a local request/acknowledge port and terminates the bus cycle with DTACK_n, or with BERR_n on local error or timeout.
- For reads it returns data on the 16-bit bus.
- All logic runs in the fast Pi-side clock domain; bus inputs are synchronised internally.

Parameters:
- ADDR_BASE, 24'hE80000, window base address (byte address; bit 0 ignored).
- ADDR_MASK, 24'hFF0000, address bits compared against ADDR_BASE.
- WAIT_STATES, 0, extra PI_CLK cycles between local ack and DTACK_n assertion (0..15).
- TIMEOUT, 255, PI_CLK cycles of LOC_REQ without ack/err before BERR_n is forced (1..255).

Ports:
- PI_CLK  in  1  single clock for the whole block.
- RST  in  1  asynchronous, active-high reset.
- M68K_A  in  23  address bits A[23:1].
- M68K_FC  in  3  function code.
- M68K_AS_n  in  1  address strobe.
- M68K_UDS_n  in  1  upper data strobe.
- M68K_LDS_n  in  1  lower data strobe.
- M68K_RW  in  1  1 = read.
- M68K_D_IN  in  16  bus data in (writes).
- M68K_D_OUT  out  16  bus data out (reads).
- M68K_D_OE  out  1  drive M68K_D_OUT onto the bus.
- M68K_DTACK_n  out  1  data acknowledge, active low.
- M68K_BERR_n  out  1  bus error, active low.
- LOC_REQ  out  1  local request.
- LOC_WE  out  1  local write enable.
- LOC_ADDR  out  23  latched A[23:1].
- LOC_BE  out  2  byte enables {upper, lower}, active high.
- LOC_WDATA  out  16  latched write data.
- LOC_RDATA  in  16  local read data, valid with LOC_ACK.
- LOC_ACK  in  1  local completion.
- LOC_ERR  in  1  local error completion.

Behaviour:
Reset:
- Reset values: DTACK_n=1, BERR_n=1, D_OE=0, D_OUT=0, LOC_REQ=0, LOC_WE=0, LOC_ADDR=0, LOC_BE=0, LOC_WDATA=0.
- Reset also clears all synchronisers to the idle level (1) and sets state IDLE.
- Reset mid-cycle releases the bus immediately (asynchronously); no local completion is awaited.

Synchronisation:
- AS_n, UDS_n, LDS_n pass through 2-flop synchronisers.
- A, FC, RW and D_IN are sampled only when the synchronised strobes qualify them.

State machine IDLE, DECODE, LOCAL, WAIT, ACK, IGNORE:
- IDLE: on synced AS low AND (synced UDS or LDS low) at cycle N, latch A, FC, RW, D_IN, and BE = {~UDS, ~LDS}; go to DECODE. Write cycles therefore wait for DS.
- DECODE (cycle N+1): hit = ((A<<1) & ADDR_MASK) == (ADDR_BASE & ADDR_MASK) AND FC != 3'b111. Hit → LOCAL with LOC_REQ=1, LOC_WE=~RW from cycle N+2. Miss → IGNORE.
- IGNORE: drive nothing; return to IDLE when synced AS high.
- LOCAL: hold LOC_REQ and the LOC_* outputs stable.
  - When LOC_ACK or LOC_ERR is sampled high at cycle M: LOC_REQ=0 from M+1, and latch LOC_RDATA into D_OUT on reads.
  - LOC_ERR has priority over a simultaneous LOC_ACK.
  - The timeout counter starts at 0 when LOC_REQ rises. If it reaches TIMEOUT with no ack/err, LOC_REQ drops and the cycle is treated as an error.
- WAIT: count WAIT_STATES cycles, then go to ACK. With WAIT_STATES=0, ACK is entered directly.
- ACK:
  - Success: DTACK_n=0 from cycle M+1+WAIT_STATES.
  - Error or timeout: BERR_n=0 instead and DTACK_n stays 1.
  - Read success: D_OE=1 from the same cycle as DTACK_n. D_OUT is stable for the whole time D_OE=1.
  - When synced AS is seen high: DTACK_n=1, BERR_n=1, D_OE=0 on the next edge, then IDLE.
- Abort: if synced AS goes high while in LOCAL or WAIT (master aborted), the local handshake still completes. The block then returns to IDLE without asserting DTACK_n, BERR_n or D_OE.
- A new cycle is never accepted until AS has been seen high after the previous one (back-to-back cycles need AS negation).
- DTACK_n and BERR_n are never both low. LOC_REQ is never high outside LOCAL.

Test Plan:
- Read hit: A=0xE80010, RW=1, UDS=LDS=0; local acks 3 cycles after LOC_REQ with RDATA=0xBEEF → LOC_BE=2'b11, LOC_WE=0, DTACK_n low one cycle after ack, D_OE=1 with D_OUT=0xBEEF, both release one cycle after synced AS high.
- Byte write: A=0xE80021, RW=0, LDS=0 only, D_IN=0x00A5 → LOC_BE=2'b01, LOC_WE=1, LOC_WDATA=0x00A5, DTACK_n asserts, D_OE stays 0.
- Miss / IACK: A=0xC00000 and, separately, A=0xE80000 with FC=7 → LOC_REQ never asserts, DTACK_n and BERR_n stay 1.
- Timeout: TIMEOUT=16, local never acks → LOC_REQ drops after 16 cycles, BERR_n=0, DTACK_n=1 until AS negates. Simultaneous LOC_ACK+LOC_ERR → BERR_n only.
- WAIT_STATES=4 → DTACK_n asserts exactly 5 cycles after the ack cycle. An AS abort during WAIT → no DTACK_n, back to IDLE.
- RST pulsed while DTACK_n=0 and D_OE=1 → both release immediately. The next cycle after reset is serviced normally.
